// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES counter-mode stream wrapper.
package aes_ctr_pkg;
  localparam int AES_BLK_W       = 128;
  localparam int AES_LATENCY_DEF = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_EXHAUSTED
  } ctr_state_e;

  // One stage of the plaintext delay line that shadows the core pipeline.
  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [AES_BLK_W-1:0] data;
  } ctr_tag_t;

  // Output FIFO entry: ciphertext block plus end-of-message tag.
  typedef struct packed {
    logic                 last;
    logic [AES_BLK_W-1:0] data;
  } ctr_res_t;
endpackage

// File: rtl/aes_ctr_stream_if.sv
// Config, plaintext, core and ciphertext signals of aes_ctr_stream.
interface aes_ctr_stream_if;
  import aes_ctr_pkg::*;

  logic                 cfg_load;
  logic [AES_BLK_W-1:0] cfg_key;
  logic [AES_BLK_W-1:0] cfg_iv;
  logic                 ctr_wrap;
  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic                 in_last;
  logic [AES_BLK_W-1:0] core_state;
  logic [AES_BLK_W-1:0] core_key;
  logic [AES_BLK_W-1:0] core_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_last;

  modport slave (
    input  cfg_load, cfg_key, cfg_iv, in_valid, in_data, in_last, core_out, out_ready,
    output ctr_wrap, in_ready, core_state, core_key, out_valid, out_data, out_last
  );

  modport master (
    output cfg_load, cfg_key, cfg_iv, in_valid, in_data, in_last, core_out, out_ready,
    input  ctr_wrap, in_ready, core_state, core_key, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_ctr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two and at least 2.
module aes_ctr_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    rdata   = empty ? '0 : mem_q[rd_q];
    count   = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/aes_ctr_stream.sv
// Counter-mode front/back end for a fixed-latency, non-stallable AES core.
// Credits (in-flight tags + FIFO occupancy) keep the core from overrunning the FIFO.
module aes_ctr_stream import aes_ctr_pkg::*; #(
  parameter int LATENCY = AES_LATENCY_DEF,
  parameter int DEPTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_ctr_stream_if.slave  bus
);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int IW    = $clog2(LATENCY+1);
  localparam int RES_W = $bits(ctr_res_t);

  ctr_state_e           state_q, state_d;
  logic [AES_BLK_W-1:0] key_q, key_d, ctr_q, ctr_d;
  ctr_tag_t             tag_q [LATENCY];
  ctr_tag_t             tag_d [LATENCY];
  logic [IW-1:0]        inflight_q, inflight_d;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty, fifo_full;
  logic [RES_W-1:0]     fifo_rdata_raw;
  ctr_res_t             fifo_rdata, fifo_wdata;
  logic [CW:0]          credit_used;
  logic                 accept, tail_push, pop, in_ready;

  always_comb begin
    credit_used = (CW+1)'(inflight_q) + (CW+1)'(fifo_count);
    in_ready    = (state_q == ST_RUN) && !bus.cfg_load && (credit_used < (CW+1)'(DEPTH));
    accept      = bus.in_valid && in_ready;

    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    if (bus.cfg_load) begin
      state_d = ST_RUN;
      key_d   = bus.cfg_key;
      ctr_d   = bus.cfg_iv;
    end else if (accept) begin
      ctr_d[31:0] = ctr_q[31:0] + 32'd1;
      if (ctr_q[31:0] == 32'hFFFF_FFFF) state_d = ST_EXHAUSTED;
    end

    // Plaintext shadows the core; the key rides in the core, so a reload never
    // disturbs blocks already launched.
    tag_d[0] = '0;
    if (accept) begin
      tag_d[0].valid = 1'b1;
      tag_d[0].last  = bus.in_last;
      tag_d[0].data  = bus.in_data;
    end
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];

    tail_push       = tag_q[LATENCY-1].valid;
    fifo_wdata.last = tag_q[LATENCY-1].last;
    fifo_wdata.data = bus.core_out ^ tag_q[LATENCY-1].data;
    inflight_d      = inflight_q + IW'(accept) - IW'(tail_push);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      ctr_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      ctr_q      <= ctr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  aes_ctr_fifo #(.W(RES_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail_push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata_raw),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    fifo_rdata     = ctr_res_t'(fifo_rdata_raw);
    bus.in_ready   = in_ready;
    bus.core_state = ctr_q;
    bus.core_key   = key_q;
    bus.ctr_wrap   = (state_q == ST_EXHAUSTED);
    bus.out_valid  = !fifo_empty;
    bus.out_data   = fifo_rdata.data;
    bus.out_last   = fifo_rdata.last;
    pop            = !fifo_empty && bus.out_ready;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) tail_push |-> !fifo_full);
endmodule
